// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and the BCD -> active-low 7-segment decode function
// used by the multiplexed display scanner.
package bcd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Nibbles above 9 are not BCD; they show a lone dash so the fault is visible.
    function automatic logic [6:0] bcd_to_seg7_f(input logic [3:0] nib);
        logic [6:0] seg_v;
        case (nib)
            4'd0:    seg_v = SEG_0;
            4'd1:    seg_v = SEG_1;
            4'd2:    seg_v = SEG_2;
            4'd3:    seg_v = SEG_3;
            4'd4:    seg_v = SEG_4;
            4'd5:    seg_v = SEG_5;
            4'd6:    seg_v = SEG_6;
            4'd7:    seg_v = SEG_7;
            4'd8:    seg_v = SEG_8;
            4'd9:    seg_v = SEG_9;
            default: seg_v = SEG_DASH;
        endcase
        return seg_v;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7_decoder.sv
// Combinational nibble -> active-low {g,f,e,d,c,b,a} segment decoder.
module bcd_seg7_decoder
    import bcd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg7_f(nib);

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous digit update.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          update,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]           prescaler_r, prescaler_nxt_s;
    logic [IW-1:0]           idx_r, idx_nxt_s;
    logic [4*NUM_DIGITS-1:0] pend_digits_r, act_digits_r, act_digits_nxt_s;
    logic [NUM_DIGITS-1:0]   pend_dp_r, act_dp_r, act_dp_nxt_s;
    logic [NUM_DIGITS-1:0]   an_r, an_nxt_s;
    logic [6:0]              seg_r, seg_nxt_s, dec_seg_s;
    logic                    dp_r, dp_nxt_s, frame_done_r;
    logic                    tick_s, wrap_s, lead_blank_s;
    logic [3:0]              nib_s;

    // Prescaler/scan-index advance and frame-boundary transfer of pending digits.
    always_comb begin
        tick_s           = en && (prescaler_r == PW'(REFRESH_DIV - 1));
        wrap_s           = tick_s && (idx_r == IW'(NUM_DIGITS - 1));
        prescaler_nxt_s  = prescaler_r;
        idx_nxt_s        = idx_r;
        act_digits_nxt_s = act_digits_r;
        act_dp_nxt_s     = act_dp_r;
        if (tick_s) begin
            prescaler_nxt_s = '0;
            idx_nxt_s       = wrap_s ? '0 : idx_r + 1'b1;
        end else if (en) begin
            prescaler_nxt_s = prescaler_r + 1'b1;
        end else begin
            prescaler_nxt_s = prescaler_r;
        end
        // A strobe coinciding with the wrap bypasses pending so it is not lost a frame.
        if (wrap_s) begin
            act_digits_nxt_s = update ? digits  : pend_digits_r;
            act_dp_nxt_s     = update ? dp_mask : pend_dp_r;
        end else begin
            act_digits_nxt_s = act_digits_r;
            act_dp_nxt_s     = act_dp_r;
        end
    end

    assign nib_s = act_digits_nxt_s[4*int'(idx_nxt_s) +: 4];

    bcd_seg7_decoder u_dec (
        .nib (nib_s),
        .seg (dec_seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    int hi_s;

    // Blank slots above the most significant nonzero digit; digit0 can never exceed it.
    always_comb begin
        hi_s = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act_digits_nxt_s[4*i +: 4] != 4'h0) begin
                hi_s = i;
            end else begin
                hi_s = hi_s;
            end
        end
        lead_blank_s = (int'(idx_nxt_s) > hi_s);
    end
`else
    assign lead_blank_s = 1'b0;
`endif

    // Next values of the display outputs, aligned with the next scan index.
    always_comb begin
        an_nxt_s  = {NUM_DIGITS{1'b1}};
        seg_nxt_s = SEG_BLANK;
        dp_nxt_s  = 1'b1;
        if (en && !lead_blank_s) begin
            an_nxt_s[idx_nxt_s] = 1'b0;
            seg_nxt_s           = dec_seg_s;
            dp_nxt_s            = ~act_dp_nxt_s[idx_nxt_s];
        end else begin
            an_nxt_s  = {NUM_DIGITS{1'b1}};
            seg_nxt_s = SEG_BLANK;
            dp_nxt_s  = 1'b1;
        end
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_r   <= '0;
            idx_r         <= '0;
            pend_digits_r <= '0;
            pend_dp_r     <= '0;
            act_digits_r  <= '0;
            act_dp_r      <= '0;
            an_r          <= {NUM_DIGITS{1'b1}};
            seg_r         <= SEG_BLANK;
            dp_r          <= 1'b1;
            frame_done_r  <= 1'b0;
        end else begin
            prescaler_r   <= prescaler_nxt_s;
            idx_r         <= idx_nxt_s;
            pend_digits_r <= update ? digits  : pend_digits_r;
            pend_dp_r     <= update ? dp_mask : pend_dp_r;
            act_digits_r  <= act_digits_nxt_s;
            act_dp_r      <= act_dp_nxt_s;
            an_r          <= an_nxt_s;
            seg_r         <= seg_nxt_s;
            dp_r          <= dp_nxt_s;
            frame_done_r  <= wrap_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign digit_idx  = idx_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (NUM_DIGITS=4, REFRESH_DIV=4):
// directed scenarios plus random traffic against a cycle-level reference model.
module tb_bcd_display_scanner;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, update;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_presc, m_idx;
    logic [15:0] m_pend_d, m_act_d;
    logic [3:0]  m_pend_p, m_act_p;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp, m_fd;
    logic [6:0]  seg_tab [16];

    always #5 clk = ~clk;

    bcd_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .update     (update),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hi_nz(input logic [15:0] d);
        int h = 0;
        for (int i = 0; i < N; i++) begin
            if (d[4*i +: 4] != 4'h0) h = i;
        end
        return h;
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        bit tick, wrap, blank;
        @(posedge clk);
        if (!rst_n) begin
            m_presc = 0; m_idx = 0;
            m_pend_d = '0; m_pend_p = '0; m_act_d = '0; m_act_p = '0;
            m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_fd = 1'b0;
        end else begin
            tick = en && (m_presc == DIV - 1);
            wrap = tick && (m_idx == N - 1);
            if (en) m_presc = (m_presc + 1) % DIV;
            if (tick) m_idx = (m_idx + 1) % N;
            if (wrap) begin
                m_act_d = update ? digits : m_pend_d;
                m_act_p = update ? dp_mask : m_pend_p;
            end
            if (update) begin
                m_pend_d = digits;
                m_pend_p = dp_mask;
            end
            m_fd = wrap;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (m_idx > hi_nz(m_act_d));
`else
            blank = 1'b0;
`endif
            if (en && !blank) begin
                m_an  = ~(4'b0001 << m_idx);
                m_seg = seg_tab[m_act_d[4*m_idx +: 4]];
                m_dp  = ~m_act_p[m_idx];
            end else begin
                m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
            end
        end
        #1;
        chk("model_an", an, m_an);
        chk("model_seg", seg, m_seg);
        chk("model_dp", dp, m_dp);
        chk("model_fd", frame_done, m_fd);
        chk("model_idx", digit_idx, m_idx[1:0]);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_fd();
        bit got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            step();
            if (frame_done === 1'b1) got = 1'b1;
        end
        chk("fd_timeout", got, 1);
    endtask

    initial begin
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        int held_idx, held_presc, cnt;
        bit seen;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};

        // 1. reset
        rst_n = 1'b0; en = 1'b0; update = 1'b0; digits = 16'h0; dp_mask = 4'h0;
        steps(2);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_fd", frame_done, 1'b0);

        // 2. scan order and slot length
        rst_n = 1'b1; en = 1'b1; digits = 16'h1234; dp_mask = 4'h0; update = 1'b1;
        step();
        update = 1'b0;
        wait_fd();
        for (int s = 0; s < 4; s++) begin
            chk("scan_an", an, exp_an[s]);
            chk("scan_seg", seg, exp_seg[s]);
            steps(4);
        end

        // 3. mid-frame strobe does not tear the current frame
        steps(4);
        digits = 16'h5678; update = 1'b1;
        step();
        update = 1'b0;
        chk("tear_seg", seg, 7'h30);
        wait_fd();
        chk("new_seg", seg, 7'h00);

        // 4. invalid nibble and per-digit decimal point
        digits = 16'h00A0; dp_mask = 4'b0010; update = 1'b1;
        step();
        update = 1'b0;
        wait_fd();
        chk("inv_dp0", dp, 1'b1);
        steps(4);
        chk("inv_seg1", seg, 7'h3F);
        chk("inv_dp1", dp, 1'b0);

        // 5. enable gating holds index and remaining slot time
        steps(6);
        en = 1'b0;
        step();
        held_idx = m_idx; held_presc = m_presc;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("gate_an", an, 4'hF);
            chk("gate_idx", digit_idx, held_idx[1:0]);
        end
        en = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20 && digit_idx == held_idx[1:0]; k++) begin
            step();
            cnt++;
        end
        chk("resume_cnt", cnt, DIV - held_presc);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            en      = ($urandom_range(0, 9) != 0);
            update  = ($urandom_range(0, 9) == 0);
            digits  = 16'($urandom);
            dp_mask = 4'($urandom);
            step();
        end
        update = 1'b0; en = 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
        // 6. leading-zero blanking
        digits = 16'h0045; dp_mask = 4'h0; update = 1'b1;
        step();
        update = 1'b0;
        wait_fd();
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (an[3] === 1'b0 || an[2] === 1'b0) seen = 1'b1;
            step();
        end
        chk("lzb_upper_dark", seen, 1'b0);
        digits = 16'h0000; update = 1'b1;
        step();
        update = 1'b0;
        wait_fd();
        chk("lzb_zero_seg", seg, 7'h40);
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (an !== 4'hE && an !== 4'hF) seen = 1'b1;
            step();
        end
        chk("lzb_only_d0", seen, 1'b0);
`endif

        // reset mid-frame blanks on the next edge
        steps(5);
        rst_n = 1'b0;
        step();
        chk("mrst_an", an, 4'hF);
        chk("mrst_seg", seg, 7'h7F);
        chk("mrst_dp", dp, 1'b1);
        chk("mrst_idx", digit_idx, 2'd0);
        rst_n = 1'b1;
        steps(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
